// File: rtl/ncpu32k_wb_pipe.sv
// Two-slot, two-stage result pipeline: stage 1 feeds operand bypass and parks
// LSU ops until load data returns; stage 2 drives the register-file write ports.
module ncpu32k_wb_pipe #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          ex_slot_1_valid,
  input  logic          ex_slot_1_rd_we,
  input  logic [AW-1:0] ex_slot_1_rd_addr,
  input  logic [DW-1:0] ex_slot_1_dout,
  input  logic          ex_slot_2_valid,
  input  logic          ex_slot_2_rd_we,
  input  logic [AW-1:0] ex_slot_2_rd_addr,
  input  logic [DW-1:0] ex_slot_2_dout,
  input  logic          ex_lsu_valid,
  input  logic          ex_lsu_in_slot_1,
  input  logic          lsu_BVALID,
  input  logic [DW-1:0] lsu_dout,
  output logic          ex_ready,
  output logic          lsu_pending,
  output logic          s1o_slot_1_BVALID,
  output logic          s1o_slot_1_rd_we,
  output logic [AW-1:0] s1o_slot_1_rd_addr,
  output logic [DW-1:0] s1o_slot_1_dout,
  output logic          s1o_slot_2_BVALID,
  output logic          s1o_slot_2_rd_we,
  output logic [AW-1:0] s1o_slot_2_rd_addr,
  output logic [DW-1:0] s1o_slot_2_dout,
  output logic          s2o_slot_1_BVALID,
  output logic          s2o_slot_1_rd_we,
  output logic [AW-1:0] s2o_slot_1_rd_addr,
  output logic [DW-1:0] s2o_slot_1_dout,
  output logic          s2o_slot_2_BVALID,
  output logic          s2o_slot_2_rd_we,
  output logic [AW-1:0] s2o_slot_2_rd_addr,
  output logic [DW-1:0] s2o_slot_2_dout,
  output logic          rf_we_1,
  output logic [AW-1:0] rf_waddr_1,
  output logic [DW-1:0] rf_wdat_1,
  output logic          rf_we_2,
  output logic [AW-1:0] rf_waddr_2,
  output logic [DW-1:0] rf_wdat_2
);

  logic [1:0]    in_valid_s;
  logic [1:0]    in_we_s;
  logic [AW-1:0] in_addr_s [2];
  logic [DW-1:0] in_dout_s [2];
  logic          in_lsu_idx_s;

  logic          adv_s;
  logic          lsu_idx_s;
  logic          lsu_ret_s;
  logic          lsu_drop_s;
  logic          waw_s;

  logic [1:0]    s1_valid_q, s1_valid_d;
  logic [1:0]    s1_bvalid_q, s1_bvalid_d;
  logic [1:0]    s1_we_q, s1_we_d;
  logic [AW-1:0] s1_addr_q [2];
  logic [AW-1:0] s1_addr_d [2];
  logic [DW-1:0] s1_dout_q [2];
  logic [DW-1:0] s1_dout_d [2];

  logic [1:0]    s2_bvalid_q, s2_bvalid_d;
  logic [1:0]    s2_we_q, s2_we_d;
  logic [AW-1:0] s2_addr_q [2];
  logic [AW-1:0] s2_addr_d [2];
  logic [DW-1:0] s2_dout_q [2];
  logic [DW-1:0] s2_dout_d [2];

  logic [1:0]    rf_we_q, rf_we_d;
  logic          lsu_pending_q, lsu_pending_d;
  logic          lsu_in_slot_1_q, lsu_in_slot_1_d;
  logic          discard_q, discard_d;
  logic          ex_ready_q, ex_ready_d;

  // Index 0 is slot 1, index 1 is slot 2.
  assign in_valid_s   = {ex_slot_2_valid, ex_slot_1_valid};
  assign in_we_s      = {ex_slot_2_rd_we, ex_slot_1_rd_we};
  assign in_addr_s[0] = ex_slot_1_rd_addr;
  assign in_addr_s[1] = ex_slot_2_rd_addr;
  assign in_dout_s[0] = ex_slot_1_dout;
  assign in_dout_s[1] = ex_slot_2_dout;
  assign in_lsu_idx_s = ~ex_lsu_in_slot_1;

  // Next-state for both stages, LSU bookkeeping and commit enables.
  always_comb begin
    adv_s           = ~lsu_pending_q;
    lsu_idx_s       = ~lsu_in_slot_1_q;
    lsu_ret_s       = lsu_BVALID & lsu_pending_q & ~discard_q;
    lsu_drop_s      = lsu_BVALID & discard_q;
    s1_valid_d      = s1_valid_q;
    s1_bvalid_d     = s1_bvalid_q;
    s1_we_d         = s1_we_q;
    s1_addr_d       = s1_addr_q;
    s1_dout_d       = s1_dout_q;
    s2_bvalid_d     = 2'b00;
    s2_we_d         = s2_we_q;
    s2_addr_d       = s2_addr_q;
    s2_dout_d       = s2_dout_q;
    lsu_pending_d   = lsu_pending_q;
    lsu_in_slot_1_d = lsu_in_slot_1_q;

    if (adv_s) begin
      for (int i = 0; i < 2; i++) begin
        s1_valid_d[i]  = in_valid_s[i] & ~flush;
        s1_bvalid_d[i] = in_valid_s[i] & ~flush & ~(ex_lsu_valid & (in_lsu_idx_s == i[0]));
        s1_we_d[i]     = in_we_s[i] & (in_addr_s[i] != {AW{1'b0}});
        s1_addr_d[i]   = in_addr_s[i];
        s1_dout_d[i]   = in_dout_s[i];
        s2_bvalid_d[i] = s1_valid_q[i];
        s2_we_d[i]     = s1_we_q[i];
        s2_addr_d[i]   = s1_addr_q[i];
        s2_dout_d[i]   = s1_dout_q[i];
      end
      lsu_pending_d   = ex_lsu_valid & ~flush;
      lsu_in_slot_1_d = ex_lsu_in_slot_1;
    end else if (flush) begin
      // A flush beats a same-cycle load return: the data is simply dropped.
      s1_valid_d    = 2'b00;
      s1_bvalid_d   = 2'b00;
      lsu_pending_d = 1'b0;
    end else if (lsu_ret_s) begin
      s1_dout_d[lsu_idx_s] = lsu_dout;
      lsu_pending_d        = 1'b0;
    end else begin
      lsu_pending_d = lsu_pending_q;
    end

    // The killed op's response is still in flight; swallow it when it lands.
    if (flush & lsu_pending_q & ~lsu_ret_s) begin
      discard_d = 1'b1;
    end else if (lsu_drop_s) begin
      discard_d = 1'b0;
    end else begin
      discard_d = discard_q;
    end

    waw_s = s2_bvalid_d[0] & s2_we_d[0] & s2_bvalid_d[1] & s2_we_d[1] &
            (s2_addr_d[0] == s2_addr_d[1]);
    rf_we_d[0] = s2_bvalid_d[0] & s2_we_d[0] & ~waw_s;
    rf_we_d[1] = s2_bvalid_d[1] & s2_we_d[1];
    ex_ready_d = ~lsu_pending_d;
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q      <= 2'b00;
      s1_bvalid_q     <= 2'b00;
      s1_we_q         <= 2'b00;
      s2_bvalid_q     <= 2'b00;
      s2_we_q         <= 2'b00;
      rf_we_q         <= 2'b00;
      lsu_pending_q   <= 1'b0;
      lsu_in_slot_1_q <= 1'b0;
      discard_q       <= 1'b0;
      ex_ready_q      <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        s1_addr_q[i] <= {AW{1'b0}};
        s1_dout_q[i] <= {DW{1'b0}};
        s2_addr_q[i] <= {AW{1'b0}};
        s2_dout_q[i] <= {DW{1'b0}};
      end
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_bvalid_q     <= s1_bvalid_d;
      s1_we_q         <= s1_we_d;
      s2_bvalid_q     <= s2_bvalid_d;
      s2_we_q         <= s2_we_d;
      rf_we_q         <= rf_we_d;
      lsu_pending_q   <= lsu_pending_d;
      lsu_in_slot_1_q <= lsu_in_slot_1_d;
      discard_q       <= discard_d;
      ex_ready_q      <= ex_ready_d;
      for (int i = 0; i < 2; i++) begin
        s1_addr_q[i] <= s1_addr_d[i];
        s1_dout_q[i] <= s1_dout_d[i];
        s2_addr_q[i] <= s2_addr_d[i];
        s2_dout_q[i] <= s2_dout_d[i];
      end
    end
  end

  assign ex_ready           = ex_ready_q;
  assign lsu_pending        = lsu_pending_q;
  assign s1o_slot_1_BVALID  = s1_bvalid_q[0];
  assign s1o_slot_1_rd_we   = s1_we_q[0];
  assign s1o_slot_1_rd_addr = s1_addr_q[0];
  assign s1o_slot_1_dout    = s1_dout_q[0];
  assign s1o_slot_2_BVALID  = s1_bvalid_q[1];
  assign s1o_slot_2_rd_we   = s1_we_q[1];
  assign s1o_slot_2_rd_addr = s1_addr_q[1];
  assign s1o_slot_2_dout    = s1_dout_q[1];
  assign s2o_slot_1_BVALID  = s2_bvalid_q[0];
  assign s2o_slot_1_rd_we   = s2_we_q[0];
  assign s2o_slot_1_rd_addr = s2_addr_q[0];
  assign s2o_slot_1_dout    = s2_dout_q[0];
  assign s2o_slot_2_BVALID  = s2_bvalid_q[1];
  assign s2o_slot_2_rd_we   = s2_we_q[1];
  assign s2o_slot_2_rd_addr = s2_addr_q[1];
  assign s2o_slot_2_dout    = s2_dout_q[1];
  assign rf_we_1            = rf_we_q[0];
  assign rf_waddr_1         = s2_addr_q[0];
  assign rf_wdat_1          = s2_dout_q[0];
  assign rf_we_2            = rf_we_q[1];
  assign rf_waddr_2         = s2_addr_q[1];
  assign rf_wdat_2          = s2_dout_q[1];

  ncpu32k_wb_pipe_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .lsu_bvalid  (lsu_BVALID),
    .lsu_pending (lsu_pending_q),
    .discard     (discard_q)
  );

endmodule

// Protocol checker: a load return must have a pending op or a discard window.
module ncpu32k_wb_pipe_chk (
  input logic clk,
  input logic rst_n,
  input logic lsu_bvalid,
  input logic lsu_pending,
  input logic discard
);
  // Stray load-data strobe detection.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(lsu_bvalid && !lsu_pending && !discard))
        else $error("ncpu32k_wb_pipe: lsu_BVALID with nothing to complete");
    end
  end
endmodule

// File: tb/tb_ncpu32k_wb_pipe.sv
// Directed plus random bench for ncpu32k_wb_pipe, checked against a
// record-level reference model of the two stages.
module tb_ncpu32k_wb_pipe;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          ex_slot_1_valid, ex_slot_1_rd_we;
  logic [AW-1:0] ex_slot_1_rd_addr;
  logic [DW-1:0] ex_slot_1_dout;
  logic          ex_slot_2_valid, ex_slot_2_rd_we;
  logic [AW-1:0] ex_slot_2_rd_addr;
  logic [DW-1:0] ex_slot_2_dout;
  logic          ex_lsu_valid, ex_lsu_in_slot_1, lsu_BVALID;
  logic [DW-1:0] lsu_dout;
  logic          ex_ready, lsu_pending;
  logic          s1o_slot_1_BVALID, s1o_slot_1_rd_we, s1o_slot_2_BVALID, s1o_slot_2_rd_we;
  logic [AW-1:0] s1o_slot_1_rd_addr, s1o_slot_2_rd_addr;
  logic [DW-1:0] s1o_slot_1_dout, s1o_slot_2_dout;
  logic          s2o_slot_1_BVALID, s2o_slot_1_rd_we, s2o_slot_2_BVALID, s2o_slot_2_rd_we;
  logic [AW-1:0] s2o_slot_1_rd_addr, s2o_slot_2_rd_addr;
  logic [DW-1:0] s2o_slot_1_dout, s2o_slot_2_dout;
  logic          rf_we_1, rf_we_2;
  logic [AW-1:0] rf_waddr_1, rf_waddr_2;
  logic [DW-1:0] rf_wdat_1, rf_wdat_2;

  always #5 clk = ~clk;

  ncpu32k_wb_pipe #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_slot_1_valid(ex_slot_1_valid), .ex_slot_1_rd_we(ex_slot_1_rd_we),
    .ex_slot_1_rd_addr(ex_slot_1_rd_addr), .ex_slot_1_dout(ex_slot_1_dout),
    .ex_slot_2_valid(ex_slot_2_valid), .ex_slot_2_rd_we(ex_slot_2_rd_we),
    .ex_slot_2_rd_addr(ex_slot_2_rd_addr), .ex_slot_2_dout(ex_slot_2_dout),
    .ex_lsu_valid(ex_lsu_valid), .ex_lsu_in_slot_1(ex_lsu_in_slot_1),
    .lsu_BVALID(lsu_BVALID), .lsu_dout(lsu_dout),
    .ex_ready(ex_ready), .lsu_pending(lsu_pending),
    .s1o_slot_1_BVALID(s1o_slot_1_BVALID), .s1o_slot_1_rd_we(s1o_slot_1_rd_we),
    .s1o_slot_1_rd_addr(s1o_slot_1_rd_addr), .s1o_slot_1_dout(s1o_slot_1_dout),
    .s1o_slot_2_BVALID(s1o_slot_2_BVALID), .s1o_slot_2_rd_we(s1o_slot_2_rd_we),
    .s1o_slot_2_rd_addr(s1o_slot_2_rd_addr), .s1o_slot_2_dout(s1o_slot_2_dout),
    .s2o_slot_1_BVALID(s2o_slot_1_BVALID), .s2o_slot_1_rd_we(s2o_slot_1_rd_we),
    .s2o_slot_1_rd_addr(s2o_slot_1_rd_addr), .s2o_slot_1_dout(s2o_slot_1_dout),
    .s2o_slot_2_BVALID(s2o_slot_2_BVALID), .s2o_slot_2_rd_we(s2o_slot_2_rd_we),
    .s2o_slot_2_rd_addr(s2o_slot_2_rd_addr), .s2o_slot_2_dout(s2o_slot_2_dout),
    .rf_we_1(rf_we_1), .rf_waddr_1(rf_waddr_1), .rf_wdat_1(rf_wdat_1),
    .rf_we_2(rf_we_2), .rf_waddr_2(rf_waddr_2), .rf_wdat_2(rf_wdat_2)
  );

  // One result record: lsu marks an op waiting on load data (never bypassable).
  typedef struct {
    bit          v;
    bit          lsu;
    bit          we;
    bit [AW-1:0] a;
    bit [DW-1:0] d;
  } rec_t;

  rec_t s1m [2];
  rec_t s2m [2];
  bit   pend_m, lsu1_m, disc_m;
  int   total = 0;
  int   bad = 0;
  int   wcount [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      s1m[i] = '{v: 1'b0, lsu: 1'b0, we: 1'b0, a: '0, d: '0};
      s2m[i] = '{v: 1'b0, lsu: 1'b0, we: 1'b0, a: '0, d: '0};
    end
    pend_m = 1'b0; lsu1_m = 1'b0; disc_m = 1'b0;
  endtask

  task automatic idle();
    flush = 1'b0; lsu_BVALID = 1'b0; lsu_dout = '0;
    ex_slot_1_valid = 1'b0; ex_slot_1_rd_we = 1'b0; ex_slot_1_rd_addr = '0; ex_slot_1_dout = '0;
    ex_slot_2_valid = 1'b0; ex_slot_2_rd_we = 1'b0; ex_slot_2_rd_addr = '0; ex_slot_2_dout = '0;
    ex_lsu_valid = 1'b0; ex_lsu_in_slot_1 = 1'b0;
  endtask

  task automatic check_all(input string ph);
    bit w0, w1;
    w0 = s2m[0].v && s2m[0].we;
    w1 = s2m[1].v && s2m[1].we;
    if (w0 && w1 && s2m[0].a == s2m[1].a) w0 = 1'b0;
    chk({ph, ":ex_ready"}, ex_ready, !pend_m);
    chk({ph, ":lsu_pending"}, lsu_pending, pend_m);
    chk({ph, ":s1_bv1"}, s1o_slot_1_BVALID, s1m[0].v && !s1m[0].lsu);
    chk({ph, ":s1_we1"}, s1o_slot_1_rd_we, s1m[0].we);
    chk({ph, ":s1_a1"}, s1o_slot_1_rd_addr, s1m[0].a);
    chk({ph, ":s1_d1"}, s1o_slot_1_dout, s1m[0].d);
    chk({ph, ":s1_bv2"}, s1o_slot_2_BVALID, s1m[1].v && !s1m[1].lsu);
    chk({ph, ":s1_we2"}, s1o_slot_2_rd_we, s1m[1].we);
    chk({ph, ":s1_a2"}, s1o_slot_2_rd_addr, s1m[1].a);
    chk({ph, ":s1_d2"}, s1o_slot_2_dout, s1m[1].d);
    chk({ph, ":s2_bv1"}, s2o_slot_1_BVALID, s2m[0].v);
    chk({ph, ":s2_we1"}, s2o_slot_1_rd_we, s2m[0].we);
    chk({ph, ":s2_a1"}, s2o_slot_1_rd_addr, s2m[0].a);
    chk({ph, ":s2_d1"}, s2o_slot_1_dout, s2m[0].d);
    chk({ph, ":s2_bv2"}, s2o_slot_2_BVALID, s2m[1].v);
    chk({ph, ":s2_we2"}, s2o_slot_2_rd_we, s2m[1].we);
    chk({ph, ":s2_a2"}, s2o_slot_2_rd_addr, s2m[1].a);
    chk({ph, ":s2_d2"}, s2o_slot_2_dout, s2m[1].d);
    chk({ph, ":rf_we1"}, rf_we_1, w0);
    chk({ph, ":rf_wa1"}, rf_waddr_1, s2m[0].a);
    chk({ph, ":rf_wd1"}, rf_wdat_1, s2m[0].d);
    chk({ph, ":rf_we2"}, rf_we_2, w1);
    chk({ph, ":rf_wa2"}, rf_waddr_2, s2m[1].a);
    chk({ph, ":rf_wd2"}, rf_wdat_2, s2m[1].d);
  endtask

  // Advance the model by one clock using the current inputs, then compare.
  task automatic step(input string ph);
    rec_t n1 [2];
    rec_t n2 [2];
    bit   np, nd, nl, ret, drop;
    n1 = s1m; n2 = s2m; np = pend_m; nd = disc_m; nl = lsu1_m;
    ret  = lsu_BVALID && pend_m && !disc_m;
    drop = lsu_BVALID && disc_m;
    if (flush && pend_m && !ret) nd = 1'b1;
    else if (drop) nd = 1'b0;
    if (!pend_m) begin
      n2 = s1m;
      n1[0].v = ex_slot_1_valid && !flush;
      n1[0].lsu = ex_lsu_valid && ex_lsu_in_slot_1;
      n1[0].we = ex_slot_1_rd_we && (ex_slot_1_rd_addr != 0);
      n1[0].a = ex_slot_1_rd_addr;
      n1[0].d = ex_slot_1_dout;
      n1[1].v = ex_slot_2_valid && !flush;
      n1[1].lsu = ex_lsu_valid && !ex_lsu_in_slot_1;
      n1[1].we = ex_slot_2_rd_we && (ex_slot_2_rd_addr != 0);
      n1[1].a = ex_slot_2_rd_addr;
      n1[1].d = ex_slot_2_dout;
      np = ex_lsu_valid && !flush;
      nl = ex_lsu_in_slot_1;
    end else begin
      n2[0].v = 1'b0;
      n2[1].v = 1'b0;
      if (flush) begin
        n1[0].v = 1'b0; n1[1].v = 1'b0; np = 1'b0;
      end else if (ret) begin
        n1[lsu1_m ? 0 : 1].d = lsu_dout;
        np = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    s1m = n1; s2m = n2; pend_m = np; disc_m = nd; lsu1_m = nl;
    check_all(ph);
    if (rf_we_1) wcount[rf_waddr_1]++;
    if (rf_we_2) wcount[rf_waddr_2]++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) wcount[i] = 0;
    rst_n = 1'b0;
    idle();
    model_reset();
    #12 rst_n = 1'b1;
    check_all("reset");

    // Back-to-back ALU results, then a WAW pair straight behind them.
    ex_slot_1_valid = 1'b1; ex_slot_1_rd_we = 1'b1; ex_slot_1_rd_addr = 5'd3; ex_slot_1_dout = 32'h11;
    ex_slot_2_valid = 1'b1; ex_slot_2_rd_we = 1'b1; ex_slot_2_rd_addr = 5'd4; ex_slot_2_dout = 32'h22;
    step("alu0");
    chk("alu_s1_bv1", s1o_slot_1_BVALID, 1'b1);
    chk("alu_s1_bv2", s1o_slot_2_BVALID, 1'b1);
    ex_slot_1_rd_addr = 5'd5; ex_slot_1_dout = 32'hA;
    ex_slot_2_rd_addr = 5'd5; ex_slot_2_dout = 32'hB;
    step("alu1");
    chk("alu_rf_we1", rf_we_1, 1'b1);
    chk("alu_rf_wd1", {rf_waddr_1, rf_wdat_1}, {5'd3, 32'h11});
    chk("alu_rf_wd2", {rf_we_2, rf_waddr_2, rf_wdat_2}, {1'b1, 5'd4, 32'h22});
    chk("alu_ready", ex_ready, 1'b1);
    chk("waw_s1_d2", {s1o_slot_1_BVALID, s1o_slot_2_BVALID, s1o_slot_2_dout}, {2'b11, 32'hB});
    idle();
    step("waw");
    chk("waw_rf_we1", rf_we_1, 1'b0);
    chk("waw_rf_2", {rf_we_2, rf_waddr_2, rf_wdat_2}, {1'b1, 5'd5, 32'hB});

    // LSU op in slot 2 writing r7, data three cycles later.
    ex_slot_2_valid = 1'b1; ex_slot_2_rd_we = 1'b1; ex_slot_2_rd_addr = 5'd7; ex_slot_2_dout = 32'h0;
    ex_lsu_valid = 1'b1; ex_lsu_in_slot_1 = 1'b0;
    step("lsu_in");
    chk("lsu_s1_we2", {s1o_slot_2_rd_we, s1o_slot_2_BVALID, s1o_slot_2_rd_addr}, {1'b1, 1'b0, 5'd7});
    chk("lsu_pend", {lsu_pending, ex_ready}, 2'b10);
    idle();
    for (int k = 0; k < 2; k++) begin
      step("lsu_wait");
      chk("lsu_wait_pend", {lsu_pending, ex_ready}, 2'b10);
      chk("lsu_bubble", {s2o_slot_1_BVALID, s2o_slot_2_BVALID}, 2'b00);
    end
    lsu_BVALID = 1'b1; lsu_dout = 32'hDEAD;
    step("lsu_ret");
    chk("lsu_ret_pend", {lsu_pending, ex_ready}, 2'b01);
    chk("lsu_ret_d", s1o_slot_2_dout, 32'hDEAD);
    idle();
    step("lsu_c");
    chk("lsu_commit", {s2o_slot_2_BVALID, rf_we_2, rf_waddr_2, rf_wdat_2}, {2'b11, 5'd7, 32'hDEAD});
    step("lsu_c2");
    chk("lsu_once", wcount[7], 1);

    // r0 is hardwired.
    ex_slot_1_valid = 1'b1; ex_slot_1_rd_we = 1'b1; ex_slot_1_rd_addr = 5'd0; ex_slot_1_dout = 32'h55;
    step("r0");
    chk("r0_s1_we", s1o_slot_1_rd_we, 1'b0);
    idle();
    step("r0b");
    chk("r0_s2", {s2o_slot_1_rd_we, rf_we_1}, 2'b00);

    // Flush with LSU pending, new LSU op, two returns: the first is dropped.
    ex_slot_1_valid = 1'b1; ex_slot_1_rd_we = 1'b1; ex_slot_1_rd_addr = 5'd9;
    ex_lsu_valid = 1'b1; ex_lsu_in_slot_1 = 1'b1;
    step("fl_in");
    idle();
    flush = 1'b1;
    step("fl");
    chk("fl_pend", {lsu_pending, ex_ready, s1o_slot_1_BVALID}, 3'b010);
    idle();
    ex_slot_1_valid = 1'b1; ex_slot_1_rd_we = 1'b1; ex_slot_1_rd_addr = 5'd10;
    ex_lsu_valid = 1'b1; ex_lsu_in_slot_1 = 1'b1;
    step("fl_new");
    idle();
    lsu_BVALID = 1'b1; lsu_dout = 32'h1;
    step("fl_drop");
    chk("fl_drop_pend", lsu_pending, 1'b1);
    lsu_dout = 32'h2;
    step("fl_take");
    chk("fl_take", {lsu_pending, s1o_slot_1_dout}, {1'b0, 32'h2});
    idle();
    step("fl_c");
    chk("fl_commit", {rf_we_1, rf_waddr_1, rf_wdat_1}, {1'b1, 5'd10, 32'h2});
    step("fl_c2");
    chk("fl_never9", wcount[9], 0);

    // Async reset in the middle of a stall.
    ex_slot_1_valid = 1'b1; ex_slot_1_rd_we = 1'b1; ex_slot_1_rd_addr = 5'd12;
    ex_lsu_valid = 1'b1; ex_lsu_in_slot_1 = 1'b1;
    step("rs_in");
    idle();
    step("rs_wait");
    #2 rst_n = 1'b0;
    #1;
    chk("rs_now", {lsu_pending, s1o_slot_1_rd_we, s1o_slot_1_rd_addr, s2o_slot_1_BVALID, rf_we_1},
        {1'b0, 1'b0, 5'd0, 1'b0, 1'b0});
    #2 rst_n = 1'b1;
    model_reset();
    check_all("rs_rel");
    step("rs_run");

    // Randomized traffic with legal load returns only.
    for (int c = 0; c < 400; c++) begin
      ex_slot_1_valid = ($urandom_range(0, 3) != 0);
      ex_slot_1_rd_we = ($urandom_range(0, 3) != 0);
      ex_slot_1_rd_addr = 5'($urandom_range(0, 7));
      ex_slot_1_dout = $urandom;
      ex_slot_2_valid = ($urandom_range(0, 3) != 0);
      ex_slot_2_rd_we = ($urandom_range(0, 3) != 0);
      ex_slot_2_rd_addr = 5'($urandom_range(0, 7));
      ex_slot_2_dout = $urandom;
      ex_lsu_in_slot_1 = ($urandom_range(0, 1) != 0);
      ex_lsu_valid = ($urandom_range(0, 3) == 0) &&
                     (ex_lsu_in_slot_1 ? ex_slot_1_valid : ex_slot_2_valid);
      flush = ($urandom_range(0, 9) == 0);
      lsu_BVALID = (pend_m || disc_m) && ($urandom_range(0, 2) == 0);
      lsu_dout = $urandom;
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
